// File: rtl/axi_slice_dc_pwr_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axi_slice_dc_pwr_pkg : shared types for the AXI slice power sequencer   |
// | rev 1.0                                                                 |
// +------------------------------------------------------------------------+
package axi_slice_dc_pwr_pkg;

    localparam int DEFAULT_DRAIN_TIMEOUT = 1024;
    localparam int DEFAULT_WAKE_DELAY    = 4;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        DRAIN   = 3'd1,
        ISOLATE = 3'd2,
        SLEEP   = 3'd3,
        WAKE    = 3'd4
    } pwr_state_e;

    typedef struct packed {
        logic clock_down;
        logic isolate;
        logic sleep_ack;
        logic busy;
    } pwr_outs_t;

    // Loaded into the output register together with the state it belongs to.
    function automatic pwr_outs_t pwr_decode(input pwr_state_e s);
        pwr_outs_t o;
        o.clock_down = (s != RUN);
        o.isolate    = (s == ISOLATE) || (s == SLEEP);
        o.sleep_ack  = (s == SLEEP);
        o.busy       = (s == DRAIN) || (s == ISOLATE) || (s == WAKE);
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_slice_dc_outstanding_cnt.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axi_slice_dc_outstanding_cnt : saturating up/down transaction counter   |
// | rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module axi_slice_dc_outstanding_cnt
    import axi_slice_dc_pwr_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Clear wins over any handshake landing in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/axi_slice_dc_pwr_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | axi_slice_dc_pwr_ctrl : drain / isolate / wake sequencer, master side   |
// | rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module axi_slice_dc_pwr_ctrl
    import axi_slice_dc_pwr_pkg::*;
#(
    parameter int CNT_WIDTH     = 8,
    parameter int DRAIN_TIMEOUT = DEFAULT_DRAIN_TIMEOUT,
    parameter int WAKE_DELAY    = DEFAULT_WAKE_DELAY
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sleep_req_i,
    input  logic incoming_req_i,
    input  logic aw_hs_i,
    input  logic ar_hs_i,
    input  logic b_hs_i,
    input  logic r_last_hs_i,
    output logic clock_down_o,
    output logic isolate_o,
    output logic sleep_ack_o,
    output logic wake_irq_o,
    output logic timeout_o,
    output logic busy_o
);

    localparam int DT_W = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int WK_W = (WAKE_DELAY > 2) ? $clog2(WAKE_DELAY) : 1;

    localparam bit              DT_EN   = (DRAIN_TIMEOUT > 0);
    localparam logic [DT_W-1:0] DT_LAST = DT_W'((DRAIN_TIMEOUT > 0) ? DRAIN_TIMEOUT - 1 : 0);
    localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);
    localparam logic [WK_W-1:0] WK_LAST = WK_W'((WAKE_DELAY > 1) ? WAKE_DELAY - 1 : 0);
    localparam logic [WK_W-1:0] WK_ONE  = WK_W'(1);

    pwr_state_e      state_q;
    pwr_outs_t       outs_q;
    logic            wake_irq_q;
    logic            timeout_q;
    logic            sleep_req_q;
    logic [DT_W-1:0] drain_tmr_q;
    logic [WK_W-1:0] wake_tmr_q;

    logic [CNT_WIDTH-1:0] w_wr_cnt;
    logic [CNT_WIDTH-1:0] w_rd_cnt;
    logic                 w_sleep_rise;
    logic                 w_cnt_idle;
    logic                 w_drain_expired;
    logic                 w_iso_entry;

    assign w_sleep_rise    = sleep_req_i & ~sleep_req_q;
    assign w_cnt_idle      = (w_wr_cnt == '0) && (w_rd_cnt == '0);
    assign w_drain_expired = DT_EN && (drain_tmr_q == DT_LAST);
    // A timed-out drain loses its R/B responses, so the counters restart here.
    assign w_iso_entry     = (state_q == DRAIN) && sleep_req_i && (w_cnt_idle || w_drain_expired);

    axi_slice_dc_outstanding_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_wr_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (w_iso_entry),
        .inc_i  (aw_hs_i),
        .dec_i  (b_hs_i),
        .cnt_o  (w_wr_cnt)
    );

    axi_slice_dc_outstanding_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_rd_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (w_iso_entry),
        .inc_i  (ar_hs_i),
        .dec_i  (r_last_hs_i),
        .cnt_o  (w_rd_cnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RUN;
            outs_q      <= '0;
            wake_irq_q  <= 1'b0;
            timeout_q   <= 1'b0;
            sleep_req_q <= 1'b0;
            drain_tmr_q <= '0;
            wake_tmr_q  <= '0;
        end else begin
            sleep_req_q <= sleep_req_i;
            wake_irq_q  <= 1'b0;
            case (state_q)
                RUN: begin
                    if (w_sleep_rise) begin
                        state_q     <= DRAIN;
                        outs_q      <= pwr_decode(DRAIN);
                        drain_tmr_q <= '0;
                    end
                end
                DRAIN: begin
                    if (!sleep_req_i) begin
                        state_q   <= RUN;
                        outs_q    <= pwr_decode(RUN);
                        timeout_q <= 1'b0;
                    end else if (w_iso_entry) begin
                        state_q <= ISOLATE;
                        outs_q  <= pwr_decode(ISOLATE);
                        if (!w_cnt_idle) begin
                            timeout_q <= 1'b1;
                        end
                    end else begin
                        drain_tmr_q <= drain_tmr_q + DT_ONE;
                    end
                end
                ISOLATE: begin
                    state_q <= SLEEP;
                    outs_q  <= pwr_decode(SLEEP);
                end
                SLEEP: begin
                    if (incoming_req_i) begin
                        state_q    <= WAKE;
                        outs_q     <= pwr_decode(WAKE);
                        wake_irq_q <= 1'b1;
                        wake_tmr_q <= '0;
                    end else if (!sleep_req_i) begin
                        state_q    <= WAKE;
                        outs_q     <= pwr_decode(WAKE);
                        wake_tmr_q <= '0;
                    end
                end
                WAKE: begin
                    // Isolation is already off; the clock returns only after the delay.
                    if (wake_tmr_q == WK_LAST) begin
                        state_q   <= RUN;
                        outs_q    <= pwr_decode(RUN);
                        timeout_q <= 1'b0;
                    end else begin
                        wake_tmr_q <= wake_tmr_q + WK_ONE;
                    end
                end
                default: begin
                    state_q <= RUN;
                    outs_q  <= pwr_decode(RUN);
                end
            endcase
        end
    end

    assign clock_down_o = outs_q.clock_down;
    assign isolate_o    = outs_q.isolate;
    assign sleep_ack_o  = outs_q.sleep_ack;
    assign busy_o       = outs_q.busy;
    assign wake_irq_o   = wake_irq_q;
    assign timeout_o    = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_slice_dc_pwr_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_axi_slice_dc_pwr_ctrl : directed vectors for the power sequencer     |
// | rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module tb_axi_slice_dc_pwr_ctrl;

    logic clk_i          = 1'b0;
    logic rst_ni         = 1'b1;
    logic sleep_req_i    = 1'b0;
    logic incoming_req_i = 1'b0;
    logic aw_hs_i        = 1'b0;
    logic ar_hs_i        = 1'b0;
    logic b_hs_i         = 1'b0;
    logic r_last_hs_i    = 1'b0;

    logic cd_a, iso_a, ack_a, irq_a, to_a, busy_a;
    logic cd_b, iso_b, ack_b, irq_b, to_b, busy_b;
    logic [5:0] outs_a;
    logic [5:0] outs_b;

    // Output bit order: {clock_down, isolate, sleep_ack, wake_irq, timeout, busy}
    assign outs_a = {cd_a, iso_a, ack_a, irq_a, to_a, busy_a};
    assign outs_b = {cd_b, iso_b, ack_b, irq_b, to_b, busy_b};

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    axi_slice_dc_pwr_ctrl #(
        .CNT_WIDTH     (8),
        .DRAIN_TIMEOUT (1024),
        .WAKE_DELAY    (4)
    ) dut_a (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .sleep_req_i    (sleep_req_i),
        .incoming_req_i (incoming_req_i),
        .aw_hs_i        (aw_hs_i),
        .ar_hs_i        (ar_hs_i),
        .b_hs_i         (b_hs_i),
        .r_last_hs_i    (r_last_hs_i),
        .clock_down_o   (cd_a),
        .isolate_o      (iso_a),
        .sleep_ack_o    (ack_a),
        .wake_irq_o     (irq_a),
        .timeout_o      (to_a),
        .busy_o         (busy_a)
    );

    axi_slice_dc_pwr_ctrl #(
        .CNT_WIDTH     (8),
        .DRAIN_TIMEOUT (16),
        .WAKE_DELAY    (4)
    ) dut_b (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .sleep_req_i    (sleep_req_i),
        .incoming_req_i (incoming_req_i),
        .aw_hs_i        (aw_hs_i),
        .ar_hs_i        (ar_hs_i),
        .b_hs_i         (b_hs_i),
        .r_last_hs_i    (r_last_hs_i),
        .clock_down_o   (cd_b),
        .isolate_o      (iso_b),
        .sleep_ack_o    (ack_b),
        .wake_irq_o     (irq_b),
        .timeout_o      (to_b),
        .busy_o         (busy_b)
    );

    typedef struct packed {
        logic [5:0] ins;   // {sleep, incoming, aw, ar, b, r_last}
        logic [5:0] outs;
        logic [7:0] wr;
        logic [7:0] rd;
    } vec_t;

    localparam int NVEC = 29;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [5:0] ins);
        {sleep_req_i, incoming_req_i, aw_hs_i, ar_hs_i, b_hs_i, r_last_hs_i} = ins;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        {sleep_req_i, incoming_req_i, aw_hs_i, ar_hs_i, b_hs_i, r_last_hs_i} = 6'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        vecs[0]  = {6'b000000, 6'b000000, 8'd0, 8'd0};  // RUN
        vecs[1]  = {6'b100000, 6'b100001, 8'd0, 8'd0};  // DRAIN
        vecs[2]  = {6'b100000, 6'b110001, 8'd0, 8'd0};  // ISOLATE
        vecs[3]  = {6'b100000, 6'b111000, 8'd0, 8'd0};  // SLEEP
        vecs[4]  = {6'b100000, 6'b111000, 8'd0, 8'd0};
        vecs[5]  = {6'b110000, 6'b100101, 8'd0, 8'd0};  // WAKE + irq
        vecs[6]  = {6'b100000, 6'b100001, 8'd0, 8'd0};
        vecs[7]  = {6'b100000, 6'b100001, 8'd0, 8'd0};
        vecs[8]  = {6'b100000, 6'b100001, 8'd0, 8'd0};
        vecs[9]  = {6'b100000, 6'b000000, 8'd0, 8'd0};  // RUN after 4 WAKE cycles
        vecs[10] = {6'b100000, 6'b000000, 8'd0, 8'd0};  // held level, no retrigger
        vecs[11] = {6'b000000, 6'b000000, 8'd0, 8'd0};
        vecs[12] = {6'b100000, 6'b100001, 8'd0, 8'd0};  // DRAIN
        vecs[13] = {6'b000000, 6'b000000, 8'd0, 8'd0};  // abort
        vecs[14] = {6'b001000, 6'b000000, 8'd1, 8'd0};  // aw
        vecs[15] = {6'b001010, 6'b000000, 8'd1, 8'd0};  // aw+b unchanged
        vecs[16] = {6'b000010, 6'b000000, 8'd0, 8'd0};  // b
        vecs[17] = {6'b000010, 6'b000000, 8'd0, 8'd0};  // b at zero ignored
        vecs[18] = {6'b000101, 6'b000000, 8'd0, 8'd0};  // ar+r_last at zero
        vecs[19] = {6'b000100, 6'b000000, 8'd0, 8'd1};  // ar
        vecs[20] = {6'b000001, 6'b000000, 8'd0, 8'd0};  // r_last
        vecs[21] = {6'b100000, 6'b100001, 8'd0, 8'd0};  // DRAIN
        vecs[22] = {6'b100000, 6'b110001, 8'd0, 8'd0};  // ISOLATE
        vecs[23] = {6'b101000, 6'b111000, 8'd1, 8'd0};  // SLEEP, aw counted
        vecs[24] = {6'b000010, 6'b100001, 8'd0, 8'd0};  // WAKE without irq
        vecs[25] = {6'b000000, 6'b100001, 8'd0, 8'd0};
        vecs[26] = {6'b000000, 6'b100001, 8'd0, 8'd0};
        vecs[27] = {6'b000000, 6'b100001, 8'd0, 8'd0};
        vecs[28] = {6'b000000, 6'b000000, 8'd0, 8'd0};  // RUN

        #2 rst_ni = 1'b0;
        #1;
        check("reset_outs_a", {26'd0, outs_a}, 32'd0);
        check("reset_wr_a", {24'd0, dut_a.w_wr_cnt}, 32'd0);
        check("reset_rd_a", {24'd0, dut_a.w_rd_cnt}, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Table-driven sweep
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].ins);
            check($sformatf("vec%0d_outs", i), {26'd0, outs_a}, {26'd0, vecs[i].outs});
            check($sformatf("vec%0d_wr", i), {24'd0, dut_a.w_wr_cnt}, {24'd0, vecs[i].wr});
            check($sformatf("vec%0d_rd", i), {24'd0, dut_a.w_rd_cnt}, {24'd0, vecs[i].rd});
        end

        // Drain with traffic: 3 AW + 2 AR outstanding, responses spread over 20 cycles
        for (int i = 0; i < 3; i++) step(6'b001000);
        for (int i = 0; i < 2; i++) step(6'b000100);
        check("traffic_wr", {24'd0, dut_a.w_wr_cnt}, 32'd3);
        check("traffic_rd", {24'd0, dut_a.w_rd_cnt}, 32'd2);
        step(6'b100000);
        check("traffic_drain", {26'd0, outs_a}, {26'd0, 6'b100001});
        for (int k = 1; k <= 21; k++) begin
            logic bk, rk;
            logic [5:0] exp_o;
            bk = (k == 3) || (k == 8) || (k == 14);
            rk = (k == 5) || (k == 19);
            step({1'b1, 1'b0, 1'b0, 1'b0, bk, rk});
            exp_o = (k <= 19) ? 6'b100001 : (k == 20) ? 6'b110001 : 6'b111000;
            check($sformatf("traffic_k%0d", k), {26'd0, outs_a}, {26'd0, exp_o});
        end
        for (int i = 0; i < 5; i++) step(6'b000000);
        check("traffic_back_run", {26'd0, outs_a}, 32'd0);

        // Timeout on the 16-cycle instance: one AW never answered
        do_reset();
        step(6'b001000);
        check("to_wr_pre", {24'd0, dut_b.w_wr_cnt}, 32'd1);
        step(6'b100000);
        check("to_drain", {26'd0, outs_b}, {26'd0, 6'b100001});
        for (int k = 1; k <= 17; k++) begin
            logic [5:0] exp_o;
            step(6'b100000);
            exp_o = (k < 16) ? 6'b100001 : (k == 16) ? 6'b110011 : 6'b111010;
            check($sformatf("to_k%0d", k), {26'd0, outs_b}, {26'd0, exp_o});
        end
        check("to_wr_cleared", {24'd0, dut_b.w_wr_cnt}, 32'd0);

        // Traffic wake with sleep_req held; timeout clears on RUN entry
        step(6'b110000);
        check("wake_irq", {26'd0, outs_b}, {26'd0, 6'b100111});
        step(6'b100000);
        check("wake_irq_gone", {26'd0, outs_b}, {26'd0, 6'b100011});
        step(6'b100000);
        step(6'b100000);
        check("wake_last", {26'd0, outs_b}, {26'd0, 6'b100011});
        step(6'b100000);
        check("wake_run", {26'd0, outs_b}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(6'b100000);
            check($sformatf("held_no_retrig%0d", i), {26'd0, outs_b}, 32'd0);
        end
        step(6'b000000);
        step(6'b100000);
        check("retrig_drain", {26'd0, outs_b}, {26'd0, 6'b100001});
        step(6'b100000);
        step(6'b100000);
        check("retrig_sleep", {26'd0, outs_b}, {26'd0, 6'b111000});

        // Asynchronous reset while asleep
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_b", {26'd0, outs_b}, 32'd0);
        check("async_rst_a", {26'd0, outs_a}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(6'b000000);
        check("after_rst_run", {26'd0, outs_b}, 32'd0);

        // Saturation at 255
        do_reset();
        for (int i = 0; i < 255; i++) step(6'b001000);
        check("sat_255", {24'd0, dut_a.w_wr_cnt}, 32'd255);
        step(6'b001000);
        check("sat_hold", {24'd0, dut_a.w_wr_cnt}, 32'd255);
        step(6'b000010);
        check("sat_dec", {24'd0, dut_a.w_wr_cnt}, 32'd254);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_slice_dc_pwr_ctrl.md
# axi_slice_dc_pwr_ctrl

Power-state sequencer for the master side of the dual-clock AXI slice. It drives the slice wrapper's `clock_down_i` and `isolate_i` inputs and tracks outstanding write and read transactions from the master-side handshakes. On a sleep request it drains in-flight transfers before isolating the port. It wakes on request withdrawal or on incoming traffic (`incoming_req_o`), and sits in the master clock domain next to the wrapper.

## Interface
- `CNT_WIDTH`, 8: width of each outstanding-transaction counter.
- `DRAIN_TIMEOUT`, 1024: maximum DRAIN cycles before forced isolation; 0 disables the timeout.
- `WAKE_DELAY`, 4: cycles spent in WAKE with isolation released and clock_down still held; minimum 1.

Ports:
- `clk_i` in 1: master-side clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `sleep_req_i` in 1: level request to power down the port.
- `incoming_req_i` in 1: from the wrapper's `incoming_req_o`.
- `aw_hs_i` in 1: master AW valid&ready.
- `ar_hs_i` in 1: master AR valid&ready.
- `b_hs_i` in 1: master B valid&ready.
- `r_last_hs_i` in 1: master R valid&ready&last.
- `clock_down_o` out 1: to the wrapper's `clock_down_i`.
- `isolate_o` out 1: to the wrapper's `isolate_i`.
- `sleep_ack_o` out 1: high while in SLEEP.
- `wake_irq_o` out 1: one-cycle pulse when traffic causes a wake.
- `timeout_o` out 1: sticky flag set when a drain timed out.
- `busy_o` out 1: high in DRAIN, ISOLATE or WAKE.

## Operation
- States (`pwr_state_e`): RUN, DRAIN, ISOLATE, SLEEP, WAKE. Reset state is RUN.
- Reset values: every output 0, both counters 0, timers 0, `sleep_req_q` 0.
- All outputs are decoded from registered state only:
  - `clock_down_o` = 1 in DRAIN, ISOLATE, SLEEP and WAKE.
  - `isolate_o` = 1 in ISOLATE and SLEEP.
- RUN → DRAIN on a rising edge of `sleep_req_i` (`sleep_req_i & ~sleep_req_q`). A level held high after a wake does not re-trigger.
- DRAIN:
  - clock_down blocks new AW/AR/W; R/B still flow to the slice.
  - `sleep_req_i`=0 → RUN (abort).
  - Otherwise, wr_cnt==0 and rd_cnt==0 → ISOLATE.
  - Otherwise, if the timeout is enabled and the timer reaches DRAIN_TIMEOUT-1 → ISOLATE and set `timeout_o`.
  - The timer clears on DRAIN entry.
- ISOLATE: unconditional → SLEEP after 1 cycle.
- SLEEP:
  - `incoming_req_i`=1 → WAKE and pulse `wake_irq_o`. This has priority.
  - Else `sleep_req_i`=0 → WAKE with no irq.
- WAKE: stay WAKE_DELAY cycles → RUN. `timeout_o` clears on RUN entry.
- Counters:
  - wr_cnt: +1 on `aw_hs_i`, −1 on `b_hs_i`. rd_cnt: +1 on `ar_hs_i`, −1 on `r_last_hs_i`.
  - Simultaneous inc and dec leaves the count unchanged.
  - Saturate at 2^CNT_WIDTH−1; decrement at 0 is ignored.
  - When a timed-out drain is isolated, the wrapper discards R/B, so both counters are cleared on ISOLATE entry.
- Handshake inputs are counted in every state.

## Timing
- `sleep_req_i` rises, sampled at edge t, with zero outstanding:
  - DRAIN at t+1;
  - ISOLATE at t+2;
  - SLEEP and `sleep_ack_o`=1 at t+3.
- Drain exit: the last B/R handshake at edge n makes the counter 0 at n; ISOLATE at n+1.
- `incoming_req_i` sampled in SLEEP at edge s:
  - `isolate_o`=0 and `wake_irq_o`=1 at s+1;
  - `clock_down_o`=0 at s+1+WAKE_DELAY.
- Wake ordering is fixed: isolation is released at least WAKE_DELAY cycles before the clock is restored.
- Reset mid-sequence: outputs drop to 0 asynchronously and the block resumes in RUN.

## Structure
- Package `axi_slice_dc_pwr_pkg`: `pwr_state_e` enum and a default-timeout localparam.
- Sub-module `axi_slice_dc_outstanding_cnt`: parameterised up/down saturating counter with sync clear, instantiated twice (write and read).
- Top holds the FSM, the drain and wake timers, and the edge detector.

## Test plan
- Idle sleep: pulse nothing, raise `sleep_req_i` → DRAIN, ISOLATE, SLEEP on 3 consecutive edges; `sleep_ack_o`=1, `isolate_o`=`clock_down_o`=1.
- Drain with traffic: 3 AW and 2 AR handshakes, then raise sleep; deliver 3 B and 2 R-last over 20 cycles → ISOLATE exactly 1 cycle after the final handshake; `timeout_o`=0.
- Timeout: DRAIN_TIMEOUT=16, 1 AW with no B → ISOLATE 16 cycles after DRAIN entry; `timeout_o`=1 and wr_cnt=0 in SLEEP.
- Traffic wake: in SLEEP assert `incoming_req_i` → `wake_irq_o` one-cycle pulse, `isolate_o`=0, `clock_down_o`=0 after WAKE_DELAY=4; a held `sleep_req_i` does not re-enter DRAIN until it toggles.
- Abort and counter edges:
  - drop `sleep_req_i` during DRAIN → RUN next cycle;
  - simultaneous `aw_hs_i` and `b_hs_i` → wr_cnt unchanged;
  - 256 AWs with CNT_WIDTH=8 → saturates at 255.
- Async reset asserted in SLEEP → all outputs 0 immediately, RUN after release.
